gfx256_pixel_arbiter: RTL and testbench
=======================================

# gfx256_pixel_arbiter

Round-robin scheduler that shares the single gfx256 pixel renderer among up to NREQ pixel sources (rasterizer, line engine, blitter, clear engine). It latches one requester's pixel operands and holds them stable for the whole render transaction. It issues a one-cycle write strobe to the renderer, waits for the renderer's completion ack, and returns a per-requester done pulse. A watchdog releases the renderer if no ack arrives.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- point_width, 16, coordinate/depth width
- TIMEOUT, 1024, cycles in WAIT before the transaction is abandoned (≥16)

Ports (one clock; reset is synchronous and active-high):
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_i  in  NREQ  per-requester request level
- req_x_i, req_y_i, req_z_i  in  NREQ*point_width each  packed operands; requester n occupies slice n
- req_color_i  in  NREQ*32  packed pixel colors
- req_zen_i, req_strip_i  in  NREQ each  z-buffer enable and strip-mode flag per requester
- req_strip_color_i  in  NREQ*256  packed strip data
- gnt_o  out  NREQ  one-hot grant, held from latch until DONE ends
- done_o  out  NREQ  one-hot pulse, one cycle, transaction finished
- err_o  out  1  pulse with done_o when the transaction ended by timeout
- busy_o  out  1  high in every state except IDLE
- pixel_x_o, pixel_y_o, pixel_z_o  out  point_width  latched operands to the renderer
- color_o  out  32  latched color
- zbuffer_enable_o, strip_o  out  1  latched flags
- strip_color_o  out  256  latched strip data
- write_o  out  1  renderer start strobe
- ack_i  in  1  renderer completion ack

## Operation
- States, held in arb_state_e: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any req_i bit is set, pick the winner g by round-robin. The search starts at (last+1) mod NREQ and wraps.
  - Latch g's operand slices into the *_o registers, set gnt_o[g], and go to ISSUE.
  - If no request is set, stay in IDLE.
- ISSUE: write_o=1 for exactly this cycle. Clear the timer and go to WAIT.
- WAIT:
  - The timer increments each cycle.
  - On ack_i: set last←g, then go to DONE.
  - When the timer reaches TIMEOUT-1 with no ack: set last←g and err flag, then go to DONE.
  - If ack_i and the timeout occur in the same cycle, ack wins and err_o=0.
- DONE:
  - done_o[g]=1, and err_o=1 if the err flag is set.
  - Clear gnt_o and the err flag, then go to IDLE.
- Requester rules:
  - req_i is a level, held until done_o is seen. The requester drops it the cycle after done_o.
  - A request still high in the IDLE cycle after its DONE is a new request.
  - Operand slices only need to be valid in the cycle the arbiter latches them (the IDLE cycle with req high).
- ack_i outside WAIT is ignored.
- Operand registers keep their last values between transactions. Only write_o starts the renderer.
- Reset mid-transaction: the arbiter returns to IDLE with no done_o, and the abandoned requester is not re-acknowledged. The renderer shares rst_i.

## Timing
- Reset values:
  - state=IDLE; last=NREQ-1, so requester 0 has first priority.
  - gnt_o, done_o, err_o, busy_o, write_o = 0.
  - All operand outputs = 0; timer = 0.
- All outputs are registered.
- Latency: req_i high in cycle 0 (IDLE) gives gnt_o and operands valid, plus write_o=1, in cycle 1. ack_i in cycle k gives done_o in cycle k+1, then IDLE in cycle k+2.
- Minimum spacing between two write_o pulses: ack latency + 3 cycles.
- Timeout: the timer counts WAIT cycles, so DONE is entered TIMEOUT cycles after ISSUE. Timer width is $clog2(TIMEOUT).
- Fairness: a requester holding req_i continuously is served within NREQ transactions.

## Structure
- gfx256_pkg holds arb_state_e (logic [1:0]) and a localparam for the default TIMEOUT.
- One sub-module, gfx256_rr_pick:
  - Combinational round-robin picker.
  - Inputs: req vector and last index. Outputs: winner index and any-valid flag.
  - Implement it with a doubled request vector plus priority encode.
  - Reusable by later memory-port arbiters.

## Test plan
- Single requester: req_i=4'b0001 with x=10, y=20, color=32'h00FF00FF and ack_i returned 6 cycles after write_o. Expect gnt_o=0001 and write_o one cycle after req; pixel_x_o=10 held until DONE; done_o=0001 one cycle after ack; err_o=0.
- All four requesting continuously, each with distinct x=n: grant order 0,1,2,3,0. Each write_o carries pixel_x_o matching the granted index.
- Round-robin wrap: last=2, req_i=4'b0101. Expect requester 0 next (search 3,0,…), then requester 2.
- Timeout: ack_i held 0. Expect done_o[g] and err_o exactly TIMEOUT+1 cycles after write_o, then the next request proceeds normally.
- Ack/timeout collision: ack_i asserted on the cycle the timer hits TIMEOUT-1. Expect done_o with err_o=0.
- Reset mid-WAIT: assert rst_i for 1 cycle. Expect all outputs 0 next cycle and no done_o. A held req_i is then re-granted starting from requester 0.

Source files
------------

// File: rtl/gfx256_pkg.sv
// Shared types and defaults for the gfx256 pixel pipeline arbiters.
package gfx256_pkg;

  localparam int unsigned DefaultTimeout = 1024;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/gfx256_rr_pick.sv
// Combinational round-robin picker: first set request after index `last`, wrapping.
module gfx256_rr_pick #(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last,
  output logic [$clog2(NREQ)-1:0] winner,
  output logic                    valid
);

  localparam int unsigned IW = $clog2(NREQ);

  logic [2*NREQ-1:0] dbl;
  logic [IW-1:0]     start;
  logic [NREQ-1:0]   rot;

  // Doubling the vector turns the wrap-around search into a plain window select.
  always_comb begin
    dbl    = {req, req};
    start  = (int'(last) == int'(NREQ) - 1) ? '0 : last + 1'b1;
    rot    = dbl[start +: NREQ];
    winner = '0;
    valid  = 1'b0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (rot[i]) begin
        winner = IW'((int'(start) + i) % int'(NREQ));
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gfx256_pixel_arbiter.sv
// Round-robin arbiter sharing one gfx256 pixel renderer between NREQ pixel sources.
module gfx256_pixel_arbiter
  import gfx256_pkg::*;
#(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned point_width = 16,
  parameter int unsigned TIMEOUT     = DefaultTimeout
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NREQ-1:0]             req_i,
  input  logic [NREQ*point_width-1:0] req_x_i,
  input  logic [NREQ*point_width-1:0] req_y_i,
  input  logic [NREQ*point_width-1:0] req_z_i,
  input  logic [NREQ*32-1:0]          req_color_i,
  input  logic [NREQ-1:0]             req_zen_i,
  input  logic [NREQ-1:0]             req_strip_i,
  input  logic [NREQ*256-1:0]         req_strip_color_i,
  output logic [NREQ-1:0]             gnt_o,
  output logic [NREQ-1:0]             done_o,
  output logic                        err_o,
  output logic                        busy_o,
  output logic [point_width-1:0]      pixel_x_o,
  output logic [point_width-1:0]      pixel_y_o,
  output logic [point_width-1:0]      pixel_z_o,
  output logic [31:0]                 color_o,
  output logic                        zbuffer_enable_o,
  output logic                        strip_o,
  output logic [255:0]                strip_color_o,
  output logic                        write_o,
  input  logic                        ack_i
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned TW = $clog2(TIMEOUT);

  arb_state_e    state;
  logic [IW-1:0] last;
  logic [IW-1:0] cur;
  logic [TW-1:0] timer;
  logic [IW-1:0] win;
  logic          win_valid;

  gfx256_rr_pick #(
    .NREQ(NREQ)
  ) u_pick (
    .req   (req_i),
    .last  (last),
    .winner(win),
    .valid (win_valid)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state            <= IDLE;
      last             <= IW'(NREQ - 1);
      cur              <= '0;
      timer            <= '0;
      gnt_o            <= '0;
      done_o           <= '0;
      err_o            <= 1'b0;
      busy_o           <= 1'b0;
      write_o          <= 1'b0;
      pixel_x_o        <= '0;
      pixel_y_o        <= '0;
      pixel_z_o        <= '0;
      color_o          <= '0;
      zbuffer_enable_o <= 1'b0;
      strip_o          <= 1'b0;
      strip_color_o    <= '0;
    end else begin
      // Strobes default low so each is a single-cycle pulse.
      done_o  <= '0;
      err_o   <= 1'b0;
      write_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (win_valid) begin
            cur              <= win;
            gnt_o            <= NREQ'(1) << win;
            pixel_x_o        <= req_x_i[win*point_width +: point_width];
            pixel_y_o        <= req_y_i[win*point_width +: point_width];
            pixel_z_o        <= req_z_i[win*point_width +: point_width];
            color_o          <= req_color_i[win*32 +: 32];
            zbuffer_enable_o <= req_zen_i[win];
            strip_o          <= req_strip_i[win];
            strip_color_o    <= req_strip_color_i[win*256 +: 256];
            write_o          <= 1'b1;
            busy_o           <= 1'b1;
            state            <= ISSUE;
          end
        end
        ISSUE: begin
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          timer <= timer + 1'b1;
          // Ack takes priority over a simultaneous timeout.
          if (ack_i) begin
            last   <= cur;
            done_o <= gnt_o;
            state  <= DONE;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            last   <= cur;
            done_o <= gnt_o;
            err_o  <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          gnt_o  <= '0;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gfx256_pixel_arbiter.sv
// Self-checking bench for gfx256_pixel_arbiter: directed scenarios plus randomized transactions.
module tb_gfx256_pixel_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned PW   = 16;
  localparam int unsigned TO   = 16;

  logic              clk = 1'b0;
  logic              rst_i = 1'b1;
  logic [NREQ-1:0]   req_i = '0;
  logic [NREQ*PW-1:0] req_x_i = '0, req_y_i = '0, req_z_i = '0;
  logic [NREQ*32-1:0] req_color_i = '0;
  logic [NREQ-1:0]   req_zen_i = '0, req_strip_i = '0;
  logic [NREQ*256-1:0] req_strip_color_i = '0;
  logic [NREQ-1:0]   gnt_o, done_o;
  logic              err_o, busy_o, write_o, zbuffer_enable_o, strip_o;
  logic [PW-1:0]     pixel_x_o, pixel_y_o, pixel_z_o;
  logic [31:0]       color_o;
  logic [255:0]      strip_color_o;
  logic              ack_i = 1'b0;

  gfx256_pixel_arbiter #(
    .NREQ       (NREQ),
    .point_width(PW),
    .TIMEOUT    (TO)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .req_i            (req_i),
    .req_x_i          (req_x_i),
    .req_y_i          (req_y_i),
    .req_z_i          (req_z_i),
    .req_color_i      (req_color_i),
    .req_zen_i        (req_zen_i),
    .req_strip_i      (req_strip_i),
    .req_strip_color_i(req_strip_color_i),
    .gnt_o            (gnt_o),
    .done_o           (done_o),
    .err_o            (err_o),
    .busy_o           (busy_o),
    .pixel_x_o        (pixel_x_o),
    .pixel_y_o        (pixel_y_o),
    .pixel_z_o        (pixel_z_o),
    .color_o          (color_o),
    .zbuffer_enable_o (zbuffer_enable_o),
    .strip_o          (strip_o),
    .strip_color_o    (strip_color_o),
    .write_o          (write_o),
    .ack_i            (ack_i)
  );

  always #5 clk = ~clk;

  int ncmp  = 0;
  int nfail = 0;
  int last_m = NREQ - 1;
  int w_exp;

  logic [PW-1:0]  xs[NREQ], ys[NREQ], zs[NREQ];
  logic [31:0]    cs[NREQ];
  logic           zens[NREQ], strs[NREQ];
  logic [255:0]   scs[NREQ];
  logic [PW-1:0]  ex_x;
  logic [31:0]    ex_c;
  logic [255:0]   ex_sc;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    ncmp++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference choice: scan upward from the requester after the last one served.
  function automatic int pick_model(input logic [NREQ-1:0] r, input int last);
    for (int k = 1; k <= int'(NREQ); k++) begin
      if (r[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic randomize_ops();
    for (int n = 0; n < int'(NREQ); n++) begin
      xs[n]   = PW'($urandom);
      ys[n]   = PW'($urandom);
      zs[n]   = PW'($urandom);
      cs[n]   = $urandom;
      zens[n] = 1'($urandom);
      strs[n] = 1'($urandom);
      for (int k = 0; k < 8; k++) scs[n][k*32 +: 32] = $urandom;
    end
  endtask

  task automatic drive_ops();
    for (int n = 0; n < int'(NREQ); n++) begin
      req_x_i[n*PW +: PW]          = xs[n];
      req_y_i[n*PW +: PW]          = ys[n];
      req_z_i[n*PW +: PW]          = zs[n];
      req_color_i[n*32 +: 32]      = cs[n];
      req_zen_i[n]                 = zens[n];
      req_strip_i[n]               = strs[n];
      req_strip_color_i[n*256 +: 256] = scs[n];
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".gnt"}, gnt_o, 0);
    check({tag, ".done"}, done_o, 0);
    check({tag, ".err"}, err_o, 0);
    check({tag, ".busy"}, busy_o, 0);
    check({tag, ".write"}, write_o, 0);
  endtask

  // Drives a request in an IDLE cycle and checks the ISSUE cycle that follows.
  task automatic begin_txn(input logic [NREQ-1:0] req, input bit keep_ops);
    if (!keep_ops) randomize_ops();
    drive_ops();
    req_i = req;
    w_exp = pick_model(req, last_m);
    ex_x  = xs[w_exp];
    ex_c  = cs[w_exp];
    ex_sc = scs[w_exp];
    step();
    check("issue.gnt", gnt_o, 1 << w_exp);
    check("issue.write", write_o, 1);
    check("issue.busy", busy_o, 1);
    check("issue.x", pixel_x_o, ex_x);
    check("issue.y", pixel_y_o, ys[w_exp]);
    check("issue.z", pixel_z_o, zs[w_exp]);
    check("issue.color", color_o, ex_c);
    check("issue.zen", zbuffer_enable_o, zens[w_exp]);
    check("issue.strip", strip_o, strs[w_exp]);
    check("issue.strip_color", strip_color_o, ex_sc);
  endtask

  // Ack arrives in WAIT cycle d (0 = first WAIT cycle); d >= TO means no ack.
  task automatic finish_txn(input int d);
    int lat_exp;
    int c;
    int bad;
    bit err_exp;
    err_exp = (d > int'(TO) - 1);
    lat_exp = err_exp ? int'(TO) + 1 : d + 2;
    ack_i = 1'($urandom);  // ignored during ISSUE
    randomize_ops();
    drive_ops();
    step();
    c   = 1;
    bad = 0;
    while (done_o == '0 && c < int'(TO) + 8) begin
      if (write_o !== 1'b0 || pixel_x_o !== ex_x || gnt_o !== NREQ'(1 << w_exp)) bad++;
      ack_i = (c - 1 == d);
      randomize_ops();
      drive_ops();
      step();
      c++;
    end
    check("done.latency", c, lat_exp);
    check("done.vec", done_o, 1 << w_exp);
    check("done.err", err_o, err_exp);
    check("done.held", bad, 0);
    check("done.x", pixel_x_o, ex_x);
    check("done.color", color_o, ex_c);
    check("done.gnt", gnt_o, 1 << w_exp);
    last_m = w_exp;
    req_i  = '0;
    ack_i  = 1'($urandom);  // ignored during DONE
    step();
    check_quiet("after_done");
    ack_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    req_i = '0;
    ack_i = 1'b0;
    step();
    rst_i  = 1'b0;
    last_m = NREQ - 1;
  endtask

  initial begin
    int order[5];
    int d;
    logic [NREQ-1:0] r;

    // Reset state
    do_reset();
    check_quiet("reset");
    check("reset.x", pixel_x_o, 0);
    check("reset.strip_color", strip_color_o, 0);

    // Single requester with fixed operands, ack six cycles after write
    randomize_ops();
    xs[0] = 16'd10;
    ys[0] = 16'd20;
    cs[0] = 32'h00FF00FF;
    begin_txn(4'b0001, 1'b1);
    finish_txn(5);

    // All four requesting continuously, x = index
    do_reset();
    order = '{0, 1, 2, 3, 0};
    for (int t = 0; t < 5; t++) begin
      randomize_ops();
      for (int n = 0; n < int'(NREQ); n++) xs[n] = PW'(n);
      begin_txn(4'b1111, 1'b1);
      check("rr.order", w_exp, order[t]);
      finish_txn(int'($urandom_range(0, 4)));
    end

    // Wrap: serve requester 2, then 0 and 2 contend
    begin_txn(4'b0100, 1'b0);
    finish_txn(1);
    begin_txn(4'b0101, 1'b0);
    check("wrap.first", w_exp, 0);
    finish_txn(0);
    begin_txn(4'b0101, 1'b0);
    check("wrap.second", w_exp, 2);
    finish_txn(2);

    // Timeout, then a normal transaction
    begin_txn(4'b0010, 1'b0);
    finish_txn(1000);
    begin_txn(4'b1000, 1'b0);
    finish_txn(3);

    // Ack on the final timer cycle, and one cycle earlier
    begin_txn(4'b0110, 1'b0);
    finish_txn(int'(TO) - 1);
    begin_txn(4'b0110, 1'b0);
    finish_txn(int'(TO) - 2);

    // Reset mid-WAIT with all requests held
    begin_txn(4'b1111, 1'b0);
    ack_i = 1'b0;
    step();
    step();
    rst_i = 1'b1;
    step();
    rst_i  = 1'b0;
    last_m = NREQ - 1;
    check_quiet("midreset");
    check("midreset.x", pixel_x_o, 0);
    begin_txn(4'b1111, 1'b0);
    check("midreset.regrant", w_exp, 0);
    finish_txn(2);

    // Randomized transactions, including idle cycles with no request
    for (int t = 0; t < 40; t++) begin
      r = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      if (r == '0) begin
        req_i = '0;
        ack_i = 1'($urandom);
        step();
        check_quiet("idle");
        ack_i = 1'b0;
      end else begin
        begin_txn(r, 1'b0);
        d = ($urandom_range(0, 7) == 0) ? 1000 : int'($urandom_range(0, TO));
        finish_txn(d);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
